// File: rtl/argmax_classifier.sv
// Argmax classifier: captures NUM_INPUTS signed neuron outputs on input_ready,
// scans them one entry per cycle, and reports the index and value of the
// largest entry with a one-cycle output_ready pulse.
module argmax_classifier #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 10,
    localparam int unsigned INDEX_WIDTH = ($clog2(NUM_INPUTS) > 0) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         input_ready,
    input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic [INDEX_WIDTH-1:0]       index,
    output logic signed [DATA_WIDTH-1:0] max_value,
    output logic                         output_ready,
    output logic                         busy
);

    typedef enum logic [1:0] {
        StWaiting  = 2'd0,
        StScanning = 2'd1,
        StDone     = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(NUM_INPUTS - 1);

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] buffer [NUM_INPUTS];
    logic [INDEX_WIDTH-1:0]       count;
    logic [INDEX_WIDTH-1:0]       best_idx;
    logic signed [DATA_WIDTH-1:0] best_val;
    logic signed [DATA_WIDTH-1:0] cand_val;
    logic                         cand_gt;

    // Select the buffer entry under the scan pointer; range-safe for any NUM_INPUTS.
    always_comb begin
        cand_val = buffer[0];
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (count == INDEX_WIDTH'(i)) begin
                cand_val = buffer[i];
            end
        end
    end

    // Strict compare keeps the lowest index among equal maxima.
    assign cand_gt = (cand_val > best_val);

    assign output_ready = (state == StDone);
    assign busy         = (state != StWaiting);

    // Capture, scan and commit sequencing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= StWaiting;
            count     <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            index     <= '0;
            max_value <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                StWaiting: begin
                    if (input_ready) begin
                        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                            buffer[i] <= inputs[i];
                        end
                        best_val <= inputs[0];
                        best_idx <= '0;
                        count    <= INDEX_WIDTH'(1);
                        if (NUM_INPUTS > 1) begin
                            state <= StScanning;
                        end else begin
                            // Single entry is trivially the maximum; commit on capture.
                            state     <= StDone;
                            index     <= '0;
                            max_value <= inputs[0];
                        end
                    end
                end
                StScanning: begin
                    if (cand_gt) begin
                        best_val <= cand_val;
                        best_idx <= count;
                    end
                    if (count == LastIdx) begin
                        // Commit includes the comparison made on this same edge.
                        state     <= StDone;
                        index     <= cand_gt ? count : best_idx;
                        max_value <= cand_gt ? cand_val : best_val;
                    end else begin
                        count <= count + INDEX_WIDTH'(1);
                    end
                end
                StDone: begin
                    state <= StWaiting;
                end
                default: begin
                    state <= StWaiting;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed, randomized, back-to-back,
// mid-scan reset and single-input builds against a behavioural argmax model.
module tb_argmax_classifier;

    localparam int DW = 32;
    localparam int N  = 10;
    localparam int IW = 4;

    typedef logic signed [DW-1:0] vec_t [N];

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 input_ready;
    vec_t                 inputs;
    logic [IW-1:0]        index;
    logic signed [DW-1:0] max_value;
    logic                 output_ready;
    logic                 busy;

    logic                 s_input_ready;
    logic signed [DW-1:0] s_inputs [1];
    logic [0:0]           s_index;
    logic signed [DW-1:0] s_max_value;
    logic                 s_output_ready;
    logic                 s_busy;

    int errors = 0;
    int checks = 0;

    // Last result the bench expects the DUT to be holding.
    logic [IW-1:0]        last_idx;
    logic signed [DW-1:0] last_max;

    always #5 clock = ~clock;

    argmax_classifier #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .input_ready  (input_ready),
        .inputs       (inputs),
        .index        (index),
        .max_value    (max_value),
        .output_ready (output_ready),
        .busy         (busy)
    );

    argmax_classifier #(.DATA_WIDTH(DW), .NUM_INPUTS(1)) dut_single (
        .clock        (clock),
        .reset        (reset),
        .input_ready  (s_input_ready),
        .inputs       (s_inputs),
        .index        (s_index),
        .max_value    (s_max_value),
        .output_ready (s_output_ready),
        .busy         (s_busy)
    );

    // Model: find the maximum value, then the first position holding it.
    function automatic void ref_argmax(input vec_t v, output int idx,
                                       output logic signed [DW-1:0] mx);
        mx = v[0];
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        idx = -1;
        foreach (v[i]) if (idx < 0 && v[i] == mx) idx = i;
    endfunction

    function automatic void scramble();
        foreach (inputs[i]) inputs[i] = $urandom;
    endfunction

    // Drive one capture, then watch 12 cycles after the capture edge.
    task automatic run_vector(input vec_t v, output int ready_cycle, output int ready_count,
                              output int busy_cycles, output logic [IW-1:0] got_idx,
                              output logic signed [DW-1:0] got_max, output logic unstable);
        @(negedge clock);
        inputs      = v;
        input_ready = 1'b1;
        ready_cycle = -1;
        ready_count = 0;
        busy_cycles = 0;
        unstable    = 1'b0;
        got_idx     = 'x;
        got_max     = 'x;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            input_ready = 1'b0;
            scramble();
            if (busy) busy_cycles++;
            if (output_ready) begin
                ready_count++;
                ready_cycle = n;
                got_idx     = index;
                got_max     = max_value;
            end else if (ready_count == 0 && (index !== last_idx || max_value !== last_max)) begin
                unstable = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        input_ready   = 1'b0;
        s_input_ready = 1'b0;
        s_inputs[0]   = '0;
        foreach (inputs[i]) inputs[i] = '0;
        #12;
        checks++;
        if (index !== '0 || max_value !== '0 || output_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got idx=%0d max=%0d rdy=%b busy=%b, expected 0 0 0 0",
                     index, max_value, output_ready, busy);
        end
        checks++;
        if (s_index !== '0 || s_max_value !== '0 || s_output_ready !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_single: got idx=%0d max=%0d rdy=%b busy=%b, expected 0 0 0 0",
                     s_index, s_max_value, s_output_ready, s_busy);
        end
        last_idx = '0;
        last_max = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_vectors(input string name, input int count, input bit directed);
        vec_t                 v;
        int                   e_idx, rc, rn, bc;
        logic signed [DW-1:0] e_max;
        logic [IW-1:0]        g_idx;
        logic signed [DW-1:0] g_max;
        logic                 unst;
        for (int k = 0; k < count; k++) begin
            if (directed) begin
                if (k == 0) v = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
                else if (k == 1) foreach (v[i]) v[i] = -8;
                else begin
                    foreach (v[i]) v[i] = 32'h8000_0000;
                    v[9] = 32'h8000_0001;
                end
            end else begin
                foreach (v[i]) begin
                    if (k % 3 == 0) v[i] = $urandom;
                    else if (k % 3 == 1) v[i] = 32'($signed($urandom_range(0, 6)) - 3);
                    else v[i] = 32'h8000_0000 | 32'($urandom_range(0, 3));
                end
            end
            ref_argmax(v, e_idx, e_max);
            run_vector(v, rc, rn, bc, g_idx, g_max, unst);
            checks++;
            if (rc != N || rn != 1) begin
                errors++;
                $display("FAIL %s[%0d] ready_timing: got cycle=%0d pulses=%0d, expected cycle=%0d pulses=1",
                         name, k, rc, rn, N);
            end
            checks++;
            if (bc != N) begin
                errors++;
                $display("FAIL %s[%0d] busy_cycles: got %0d, expected %0d", name, k, bc, N);
            end
            checks++;
            if (g_idx !== IW'(e_idx)) begin
                errors++;
                $display("FAIL %s[%0d] index: got %0d, expected %0d", name, k, g_idx, e_idx);
            end
            checks++;
            if (g_max !== e_max) begin
                errors++;
                $display("FAIL %s[%0d] max_value: got %0d, expected %0d", name, k, g_max, e_max);
            end
            checks++;
            if (unst !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d] hold_during_scan: got changing outputs, expected %0d/%0d held",
                         name, k, last_idx, last_max);
            end
            last_idx = IW'(e_idx);
            last_max = e_max;
        end
    endtask

    task automatic test_back_to_back();
        vec_t                 vecs [34];
        int                   e_idx;
        logic signed [DW-1:0] e_max;
        logic                 exp_busy, exp_rdy;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clock);
            if (k >= 1) begin
                exp_busy = (k % 11) != 0;
                exp_rdy  = (k % 11) == 10;
                checks++;
                if (busy !== exp_busy || output_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL b2b_cycle%0d: got busy=%b rdy=%b, expected busy=%b rdy=%b",
                             k, busy, output_ready, exp_busy, exp_rdy);
                end
                if (exp_rdy) begin
                    ref_argmax(vecs[k-10], e_idx, e_max);
                    checks++;
                    if (index !== IW'(e_idx) || max_value !== e_max) begin
                        errors++;
                        $display("FAIL b2b_result%0d: got idx=%0d max=%0d, expected idx=%0d max=%0d",
                                 k, index, max_value, e_idx, e_max);
                    end
                    last_idx = IW'(e_idx);
                    last_max = e_max;
                end
            end
            if (k < 33) begin
                foreach (vecs[k][i]) vecs[k][i] = $urandom;
                inputs      = vecs[k];
                input_ready = 1'b1;
            end else begin
                input_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        vec_t                 v;
        int                   rc, rn, bc, pulses;
        logic [IW-1:0]        g_idx;
        logic signed [DW-1:0] g_max;
        logic                 unst;
        foreach (v[i]) v[i] = $urandom;
        @(negedge clock);
        inputs      = v;
        input_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            input_ready = 1'b0;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (index !== '0 || max_value !== '0 || busy !== 1'b0 || output_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got idx=%0d max=%0d busy=%b rdy=%b, expected 0 0 0 0",
                     index, max_value, busy, output_ready);
        end
        @(negedge clock);
        checks++;
        if (index !== '0 || max_value !== '0 || busy !== 1'b0 || output_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_held: got idx=%0d max=%0d busy=%b rdy=%b, expected 0 0 0 0",
                     index, max_value, busy, output_ready);
        end
        reset    = 1'b1;
        last_idx = '0;
        last_max = '0;
        pulses   = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (output_ready || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_no_result: got %0d active cycles, expected 0", pulses);
        end
        v = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 0};
        run_vector(v, rc, rn, bc, g_idx, g_max, unst);
        checks++;
        if (rc != N || rn != 1 || g_idx !== 4'd3 || g_max !== 32'sd5 || unst !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh: got cyc=%0d n=%0d idx=%0d max=%0d unst=%b, expected %0d 1 3 5 0",
                     rc, rn, g_idx, g_max, unst, N);
        end
        last_idx = 4'd3;
        last_max = 32'sd5;
    endtask

    task automatic test_single();
        logic signed [DW-1:0] val;
        for (int k = 0; k < 3; k++) begin
            val = (k == 0) ? -32'sd42 : $urandom;
            @(negedge clock);
            s_inputs[0]   = val;
            s_input_ready = 1'b1;
            @(negedge clock);
            s_input_ready = 1'b0;
            s_inputs[0]   = $urandom;
            checks++;
            if (s_output_ready !== 1'b1 || s_busy !== 1'b1 || s_index !== 1'b0 || s_max_value !== val) begin
                errors++;
                $display("FAIL single[%0d]: got rdy=%b busy=%b idx=%0d max=%0d, expected 1 1 0 %0d",
                         k, s_output_ready, s_busy, s_index, s_max_value, val);
            end
            @(negedge clock);
            checks++;
            if (s_output_ready !== 1'b0 || s_busy !== 1'b0 || s_max_value !== val) begin
                errors++;
                $display("FAIL single_after[%0d]: got rdy=%b busy=%b max=%0d, expected 0 0 %0d",
                         k, s_output_ready, s_busy, s_max_value, val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors("directed", 3, 1'b1);
        test_vectors("random", 12, 1'b0);
        test_back_to_back();
        test_reset_mid_scan();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
